// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, op helpers.
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_t;

  // Multi-cycle ops: the ones that raise busy.
  function automatic logic is_muldiv(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_divider.sv
// Iterative restoring divider. Works on magnitudes, several quotient bits per
// clock so that WIDTH bits fit inside STEPS cycles. The result outputs already
// include the step that the current cycle would perform, so the owner can
// capture the final answer on the same edge its latency counter expires.
module mdu_divider #(
  parameter int WIDTH = 32,
  parameter int STEPS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             sign_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int BPC  = (WIDTH + STEPS - 1) / STEPS;
  localparam int CNTW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CNTW-1:0]  left_q;
  logic             neg_q, neg_r;

  logic [WIDTH-1:0] rem_c, quo_c;
  logic [WIDTH:0]   rem_t;
  logic [CNTW-1:0]  left_c;

  logic             a_neg, b_neg;

  assign a_neg = sign_op & dividend[WIDTH-1];
  assign b_neg = sign_op & divisor[WIDTH-1];

  // Up to BPC shift/subtract steps on the current partial state.
  always_comb begin
    rem_c  = rem_q;
    quo_c  = quo_q;
    left_c = left_q;
    rem_t  = '0;
    for (int i = 0; i < BPC; i++) begin
      if (left_c != '0) begin
        rem_t = {rem_c, quo_c[WIDTH-1]};
        quo_c = {quo_c[WIDTH-2:0], 1'b0};
        if (rem_t >= {1'b0, dvs_q}) begin
          rem_t    = rem_t - {1'b0, dvs_q};
          quo_c[0] = 1'b1;
        end
        rem_c  = rem_t[WIDTH-1:0];
        left_c = left_c - 1'b1;
      end
    end
  end

  // Load magnitudes and sign fix-up flags, then advance each cycle until done.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      left_q   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (load) begin
      rem_q    <= '0;
      quo_q    <= a_neg ? -dividend : dividend;
      dvs_q    <= b_neg ? -divisor : divisor;
      left_q   <= CNTW'(WIDTH);
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= (divisor == '0);
    end else if (left_q != '0) begin
      rem_q  <= rem_c;
      quo_q  <= quo_c;
      left_q <= left_c;
    end
  end

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  always_comb begin
    quotient  = neg_q ? -quo_c : quo_c;
    remainder = neg_r ? -rem_c : rem_c;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   state | meaning
//   IDLE  | busy=0, accepts start
//   RUN   | mul/div in flight, counter runs down to completion
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  output logic                busy,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo
);

  localparam int MAXN = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXN + 1);

  mdu_state_t          state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [MDU_OP_W-1:0] op_q;
  logic [WIDTH-1:0]    a_q, b_q;

  logic                accept, go_md, done;
  logic [2*WIDTH-1:0]  ext_a, ext_b, prod;
  logic [WIDTH-1:0]    div_q, div_r;
  logic                div_zero;

  assign accept = start & (state_q == IDLE);
  assign go_md  = accept & is_muldiv(op);
  assign done   = (state_q == RUN) && (cnt_q == '0);

  // Operands are held stable in a_q/b_q, so one wide product is ready long before completion.
  always_comb begin
    if (op_q == MDU_MULT) begin
      ext_a = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      ext_b = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end else begin
      ext_a = {{WIDTH{1'b0}}, a_q};
      ext_b = {{WIDTH{1'b0}}, b_q};
    end
    prod = ext_a * ext_b;
  end

  mdu_divider #(
    .WIDTH (WIDTH),
    .STEPS (DIV_CYCLES)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (accept & is_div(op)),
    .sign_op   (op == MDU_DIV),
    .dividend  (A),
    .divisor   (B),
    .quotient  (div_q),
    .remainder (div_r),
    .div_zero  (div_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: leave IDLE on an accepted mul/div, return when the counter expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go_md) state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy = (state_q == RUN);
  end

  // Latency counter, operand latches and HI/LO writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (go_md) begin
        op_q  <= op;
        a_q   <= A;
        b_q   <= B;
        cnt_q <= is_div(op) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
      end else if ((state_q == RUN) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (accept && (op == MDU_MTHI)) hi <= A;
      if (accept && (op == MDU_MTLO)) lo <= A;

      if (done) begin
        if (is_div(op_q)) begin
          if (!div_zero) begin
            hi <= div_r;
            lo <= div_q;
          end
        end else begin
          hi <= prod[2*WIDTH-1:WIDTH];
          lo <= prod[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, hand-written corner sequences
// and randomized ops against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mult_div_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int latency(input logic [2:0] o);
    if (o <= 3'd1) return MC;
    if (o <= 3'd3) return DC;
    return 0;
  endfunction

  // Architectural effect of one accepted op, from plain arithmetic.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint     sx, sy, sq, sr;
    logic [63:0] p;
    case (o)
      3'd0: begin
        p = 64'(longint'($signed(x)) * longint'($signed(y)));
        exp_hi = p[63:32]; exp_lo = p[31:0];
      end
      3'd1: begin
        p = {32'b0, x} * {32'b0, y};
        exp_hi = p[63:32]; exp_lo = p[31:0];
      end
      3'd2: if (y != 0) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sq = sx / sy;
        sr = sx % sy;
        exp_lo = sq[31:0]; exp_hi = sr[31:0];
      end
      3'd3: if (y != 0) begin
        exp_lo = x / y; exp_hi = x % y;
      end
      3'd4: exp_hi = x;
      3'd5: exp_lo = x;
      default: ;
    endcase
  endtask

  // Issue one op, optionally pulse a junk start mid-flight, and measure busy length
  // and whether HI/LO moved while busy.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit junk, output int n, output int hold_bad);
    logic [W-1:0] old_hi, old_lo;
    old_hi = hi; old_lo = lo;
    n = 0; hold_bad = 0;
    start = 1'b1; op = o; a = x; b = y;
    tick;
    start = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      if (hi !== old_hi || lo !== old_lo) hold_bad++;
      if (junk && n == 1) begin
        start = 1'b1;
        op = 3'($urandom_range(0, 7));
        a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      tick;
      n++;
    end
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, hb;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;

    tbl[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE, MC};
    tbl[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, MC};
    tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
    tbl[3] = '{3'd3, 32'd7,         32'd2,          32'd1,         32'd3,         DC};
    tbl[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, DC};
    tbl[5] = '{3'd4, 32'h1234_5678, 32'd0,          32'h1234_5678, 32'h8000_0000, 0};
    tbl[6] = '{3'd5, 32'h9ABC_DEF0, 32'd0,          32'h1234_5678, 32'h9ABC_DEF0, 0};
    tbl[7] = '{3'd3, 32'd5,         32'd0,          32'h1234_5678, 32'h9ABC_DEF0, DC};
    tbl[8] = '{3'd6, 32'd1,         32'd1,          32'h1234_5678, 32'h9ABC_DEF0, 0};
    tbl[9] = '{3'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, DC};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) tick;
    check("reset busy", 64'(busy), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    reset = 1'b0;
    tick;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, n, hb);
      model(tbl[i].op, tbl[i].a, tbl[i].b);
      check($sformatf("vec%0d cycles", i), 64'(n), 64'(tbl[i].cyc));
      check($sformatf("vec%0d hold", i), 64'(hb), 64'd0);
      check($sformatf("vec%0d hi", i), 64'(hi), 64'(tbl[i].hi));
      check($sformatf("vec%0d lo", i), 64'(lo), 64'(tbl[i].lo));
    end

    // Abort: MULT in flight, ignored MTLO pulse, then reset.
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    tick;
    start = 1'b0;
    tick;
    start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF;
    tick;
    start = 1'b0;
    check("abort busy", 64'(busy), 64'd1);
    check("abort mtlo ignored", 64'(lo), 64'(exp_lo));
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check("abort reset busy", 64'(busy), 64'd0);
    check("abort reset hi", 64'(hi), 64'd0);
    check("abort reset lo", 64'(lo), 64'd0);
    repeat (12) tick;
    check("abort late busy", 64'(busy), 64'd0);
    check("abort late hi", 64'(hi), 64'd0);
    check("abort late lo", 64'(lo), 64'd0);

    // Back-to-back: start on the completion edge is dropped, one cycle later it is taken.
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    tick;
    start = 1'b0;
    repeat (MC - 1) tick;
    check("b2b still busy", 64'(busy), 64'd1);
    start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd2;
    tick;
    check("b2b done busy", 64'(busy), 64'd0);
    check("b2b first lo", 64'(lo), 64'd15);
    check("b2b first hi", 64'(hi), 64'd0);
    tick;
    start = 1'b0;
    check("b2b accepted", 64'(busy), 64'd1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick;
      n++;
    end
    check("b2b second cycles", 64'(n), 64'(MC));
    check("b2b second lo", 64'(lo), 64'd4);
    check("b2b second hi", 64'(hi), 64'd0);
    exp_hi = 32'd0; exp_lo = 32'd4;

    // Randomized ops with junk starts during busy.
    for (int i = 0; i < 200; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, ($urandom_range(0, 1) == 1), n, hb);
      model(ro, ra, rb);
      check($sformatf("rnd%0d op%0d cycles", i, ro), 64'(n), 64'(latency(ro)));
      check($sformatf("rnd%0d hold", i), 64'(hb), 64'd0);
      check($sformatf("rnd%0d op%0d a=%0h b=%0h hi", i, ro, ra, rb), 64'(hi), 64'(exp_hi));
      check($sformatf("rnd%0d op%0d a=%0h b=%0h lo", i, ro, ra, rb), 64'(lo), 64'(exp_lo));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits beside the combinational ALU in the EX stage of the MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Raises busy for a fixed latency so the hazard unit can stall HI/LO consumers.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (>=8).
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (>=1).
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (>=1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request strobe; op, A and B are sampled when start=1.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (no-op).
- A  in  WIDTH  rs operand (multiplicand/dividend; source for MTHI/MTLO).
- B  in  WIDTH  rt operand (multiplier/divisor).
- busy  out  1  high while an operation is in flight.
- hi  out  WIDTH  HI register, registered output.
- lo  out  WIDTH  LO register, registered output.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - Clock edge with reset=1 sets busy=0, hi=0, lo=0 and the internal counter to 0.
  - An in-flight operation is discarded with no HI/LO write.
- Idle: busy=0. A start is accepted only when busy=0.
  - A start while busy=1 is ignored: no state change and no queuing.
- MULT/MULTU/DIV/DIVU accepted at edge k:
  - Operands and op are latched at edge k.
  - busy=1 from edge k to edge k+N, where N=MULT_CYCLES or DIV_CYCLES.
  - At edge k+N: busy returns to 0 and hi/lo take the result in the same edge.
  - The new values are visible from edge k+N onward.
  - hi/lo keep their old values throughout the busy interval.
  - A new start may be accepted at edge k+N+1 (the first edge sampling busy=0).
- MULT: the signed 2*WIDTH product gives hi=upper WIDTH bits, lo=lower WIDTH bits.
- MULTU: the same split, computed on the unsigned product.
- DIV: signed; lo=quotient truncated toward zero, hi=remainder carrying the sign of the dividend.
  - MIN_INT / -1 gives lo=MIN_INT, hi=0 (wrap, no trap).
- DIVU: unsigned quotient in lo, remainder in hi.
- Divide by zero (B=0, DIV or DIVU):
  - busy still runs for the full DIV_CYCLES.
  - hi/lo are left unchanged at completion.
- MTHI/MTLO accepted at edge k:
  - hi (or lo) <= A at edge k. busy is never raised.
  - The other register is unchanged.
- Reserved op with start=1: ignored, busy stays 0.
- The internal method is free (single-shot result then delay, or iterative shift/subtract). It must be bit-exact and meet the exact latency above.
- Counter width: clog2(max(MULT_CYCLES,DIV_CYCLES)+1). No wrap-around is reachable.
- Simultaneous events:
  - reset with start: reset wins.
  - Completion edge with start=1: the start is ignored, because busy=1 is sampled on that edge.

Decomposition:
- Shared package mdu_pkg holds:
  - op code localparams MDU_MULT..MDU_MTLO;
  - the op width constant (3);
  - the state enum IDLE/RUN.
- Two-state FSM: IDLE -> RUN on an accepted mul/div; RUN -> IDLE when the counter reaches N.
- One natural sub-module, mdu_divider: iterative signed/unsigned divider with a div-by-zero flag. The multiply path stays inline.

Test Plan:
- MULT A=0xFFFFFFFF, B=2 -> busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU A=7, B=2 -> lo=3, hi=1.
- DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload MTHI 0x12345678 and MTLO 0x9ABCDEF0, then DIVU with B=0 -> busy for 10 cycles; hi/lo remain 0x12345678 / 0x9ABCDEF0.
  - MTHI must update hi on the very next edge with busy=0.
- Start a MULT, then pulse start (MTLO A=0xDEADBEEF) at cycle 2 and assert reset at cycle 3.
  - The MTLO pulse is ignored.
  - Reset gives busy=0, hi=lo=0 on the next edge.
  - No late HI/LO write occurs afterward.
- Back-to-back: a start on the completion edge is ignored; the same start one cycle later is accepted (busy rises again).
